sw_conditioner: RTL and testbench

Input conditioner between the raw board slide switches and the back-end processing unit's SW[2:0] input. Each switch bit is synchronised into the CPU clock domain and debounced by a per-bit counter/FSM. The block emits a clean level plus one-cycle rise/fall pulses, so the back end sees exactly one transition per physical switch flip. It is clocked by the CPU clock and reset from the clock manager's reset.

---
 rtl/sw_conditioner_pkg.sv | 18 +
 rtl/sw_debounce_bit.sv | 82 ++++++++
 rtl/sw_conditioner.sv | 71 +++++++
 tb/tb_sw_conditioner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sw_conditioner_pkg.sv
// Shared constants for the slide-switch conditioner: per-bit FSM state
// encoding and the board / simulation debounce lengths.
package sw_conditioner_pkg;

  // state      | meaning
  // ST_STABLE  | level matches the synchronised switch, counter idle at 0
  // ST_PENDING | candidate change under test, counter counting stable cycles
  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  localparam int SYNC_STAGES_DEFAULT = 2;
  // 10 ms at the 50 MHz CPU clock
  localparam int DEBOUNCE_DEFAULT    = 500000;
  localparam int CNT_W_DEFAULT       = 20;
  // Short debounce used by simulation builds so benches stay fast
  localparam int DEBOUNCE_SIM        = 4;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: input synchroniser, two-state debounce FSM with a
// stable-cycle counter, registered rise/fall pulses.
// init_load : load the synchronised value straight into level (no pulse)
// init_val  : 1 once the power-on level is valid; the FSM idles while 0
module sw_debounce_bit
  import sw_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic init_load,
  input  logic init_val,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   state;
  logic [CNT_W-1:0]       cnt;

  // Shift the raw pin through the synchroniser chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce FSM: accept a change only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (init_load) begin
        level <= sync;
        state <= ST_STABLE;
        cnt   <= '0;
      end else if (init_val) begin
        if (state == ST_STABLE) begin
          if (sync != level) begin
            state <= ST_PENDING;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end else begin
          if (sync == level) begin
            // bounced back before the window closed: drop the candidate
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            level <= sync;
            rise  <= sync;
            fall  <= ~sync;
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign busy = (state == ST_PENDING);

endmodule

// File: rtl/sw_conditioner.sv
// Slide-switch conditioner: WIDTH independent synchronise+debounce channels
// feeding the back-end SW input, with per-bit rise/fall pulses.
// Optional build macro SW_INIT_SAMPLE_EN: after reset the synchronised
// switch positions are loaded into sw_out once, without pulses.
module sw_conditioner
  import sw_conditioner_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic [WIDTH-1:0] sw_busy
);

  logic init_load;
  logic init_gate;

`ifdef SW_INIT_SAMPLE_EN
  localparam int INIT_W = $clog2(SYNC_STAGES + 1);

  logic [INIT_W-1:0] init_cnt;
  logic              init_done;

  // The synchroniser is full after SYNC_STAGES edges; load on the next one
  assign init_load = !init_done && (init_cnt == INIT_W'(SYNC_STAGES));
  assign init_gate = init_done;

  // Count out the synchroniser fill time once after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      if (init_load) init_done <= 1'b1;
      else           init_cnt  <= init_cnt + INIT_W'(1);
    end
  end
`else
  assign init_load = 1'b0;
  assign init_gate = 1'b1;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .raw      (sw_raw[i]),
      .init_load(init_load),
      .init_val (init_gate),
      .level    (sw_out[i]),
      .rise     (sw_rise[i]),
      .fall     (sw_fall[i]),
      .busy     (sw_busy[i])
    );
  end

  assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sw_conditioner;
  import sw_conditioner_pkg::*;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] sw_raw = '0;
  logic [WIDTH-1:0] sw_out, sw_rise, sw_fall, sw_busy;
  logic             sw_changed;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] acc_pulse, acc_busy, acc_out;

  sw_conditioner #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_SIM),
    .CNT_W          (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_out    (sw_out),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed),
    .sw_busy   (sw_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_acc(input int n);
    repeat (n) begin
      @(negedge clk);
      acc_pulse |= sw_rise | sw_fall;
      acc_busy  |= sw_busy;
      acc_out   |= sw_out;
    end
  endtask

  initial begin
    // reset state
    tick(2);
    check("rst_out", sw_out, 3'b000);
    check("rst_rise", sw_rise, 3'b000);
    check("rst_fall", sw_fall, 3'b000);
    check("rst_changed", sw_changed, 1'b0);
    check("rst_busy", sw_busy, 3'b000);

    // 1: clean rise on bit 0
    rst = 1'b1;
    tick(10);
    sw_raw[0] = 1'b1;
    tick(2);
    check("t1_busy_sync", sw_busy, 3'b000);
    tick(1);
    check("t1_busy_pend", sw_busy, 3'b001);
    tick(2);
    check("t1_out_early", sw_out, 3'b000);
    check("t1_rise_early", sw_rise, 3'b000);
    tick(1);
    check("t1_out", sw_out, 3'b001);
    check("t1_rise", sw_rise, 3'b001);
    check("t1_fall", sw_fall, 3'b000);
    check("t1_changed", sw_changed, 1'b1);
    check("t1_busy_done", sw_busy, 3'b000);
    tick(1);
    check("t1_rise_gone", sw_rise, 3'b000);
    check("t1_changed_gone", sw_changed, 1'b0);
    check("t1_out_hold", sw_out, 3'b001);

    // 2: bounce rejection on bit 1
    acc_pulse = '0; acc_busy = '0; acc_out = '0;
    for (int i = 0; i < 6; i++) begin
      sw_raw[1] = ((i / 2) % 2 == 1);
      tick_acc(1);
    end
    sw_raw[1] = 1'b1;
    tick_acc(5);
    check("t2_no_pulse", acc_pulse, 3'b000);
    check("t2_busy_seen", acc_busy & 3'b010, 3'b010);
    check("t2_out_early", sw_out, 3'b001);
    tick(1);
    check("t2_out", sw_out, 3'b011);
    check("t2_rise", sw_rise, 3'b010);

    // 3: simultaneous rise and falls
    tick(2);
    sw_raw = 3'b100;
    tick(5);
    check("t3_out_early", sw_out, 3'b011);
    tick(1);
    check("t3_out", sw_out, 3'b100);
    check("t3_rise", sw_rise, 3'b100);
    check("t3_fall", sw_fall, 3'b011);
    check("t3_changed", sw_changed, 1'b1);
    tick(1);
    check("t3_changed_gone", sw_changed, 1'b0);
    check("t3_pulses_gone", sw_rise | sw_fall, 3'b000);

    // 4: reset in the middle of a pending change
    sw_raw = 3'b000;
    tick(8);
    check("t4_base", sw_out, 3'b000);
    sw_raw = 3'b100;
    tick(5);
    check("t4_busy", sw_busy, 3'b100);
    rst = 1'b0;
    #1;
    check("t4_async_busy", sw_busy, 3'b000);
    check("t4_async_out", sw_out, 3'b000);
    check("t4_async_pulse", {sw_rise, sw_fall, sw_changed}, 7'b0);
    tick(2);
    check("t4_rst_out", sw_out, 3'b000);
    rst = 1'b1;
`ifdef SW_INIT_SAMPLE_EN
    tick(2);
    check("t4_init_early", sw_out, 3'b000);
    tick(1);
    check("t4_init_out", sw_out, 3'b100);
    check("t4_init_rise", sw_rise, 3'b000);
`else
    tick(5);
    check("t4_out_early", sw_out, 3'b000);
    check("t4_busy_again", sw_busy, 3'b100);
    tick(1);
    check("t4_out", sw_out, 3'b100);
    check("t4_rise", sw_rise, 3'b100);
`endif

    // 5: switches high through reset
    rst = 1'b0;
    sw_raw = 3'b101;
    tick(2);
    check("t5_rst_out", sw_out, 3'b000);
    rst = 1'b1;
`ifdef SW_INIT_SAMPLE_EN
    acc_pulse = '0; acc_busy = '0; acc_out = '0;
    tick_acc(2);
    check("t5_init_early", sw_out, 3'b000);
    tick_acc(1);
    check("t5_init_out", sw_out, 3'b101);
    tick_acc(5);
    check("t5_init_no_pulse", acc_pulse, 3'b000);
`else
    tick(5);
    check("t5_out_early", sw_out, 3'b000);
    tick(1);
    check("t5_out", sw_out, 3'b101);
    check("t5_rise", sw_rise, 3'b101);
    check("t5_changed", sw_changed, 1'b1);
    tick(1);
    check("t5_rise_gone", sw_rise, 3'b000);
`endif

    // 6: three-cycle glitch on bit 0 is rejected
    sw_raw = 3'b000;
    tick(8);
    check("t6_base", sw_out, 3'b000);
    acc_pulse = '0; acc_busy = '0; acc_out = '0;
    sw_raw[0] = 1'b1;
    tick_acc(3);
    sw_raw[0] = 1'b0;
    tick_acc(8);
    check("t6_no_pulse", acc_pulse, 3'b000);
    check("t6_no_out", acc_out, 3'b000);
    check("t6_busy_seen", acc_busy, 3'b001);
    check("t6_busy_end", sw_busy, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
